rop_frag_queue: RTL and testbench

Parametrised fragment queue for the ROP unit. It sits between the ROP request interface and the depth/stencil/blend pipeline, and buffers per-warp fragment entries of `NUM_LANES` lanes. Each stored entry is re-issued as one or more narrower `OUT_LANES`-wide beats. Entries whose thread mask is all-zero are dropped on entry, and beats whose sub-mask is all-zero are skipped.

---
 rtl/rop_frag_queue.sv | 141 ++++++++++++++
 tb/tb_rop_frag_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rop_frag_queue.sv
// ROP fragment queue: buffers NUM_LANES-wide fragment entries and
// re-issues each as OUT_LANES-wide beats, skipping empty chunks.
module rop_frag_queue #(
    parameter int NUM_LANES  = 4,
    parameter int OUT_LANES  = 2,
    parameter int QUEUE_SIZE = 4,
    parameter int DIM_BITS   = 16,
    parameter int DEPTH_BITS = 24,
    localparam int NUM_CHUNKS = NUM_LANES / OUT_LANES,
    localparam int CHUNK_BITS = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    localparam int CNT_BITS   = $clog2(QUEUE_SIZE + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_LANES-1:0]            in_tmask,
    input  logic [NUM_LANES*DIM_BITS-1:0]   in_pos_x,
    input  logic [NUM_LANES*DIM_BITS-1:0]   in_pos_y,
    input  logic [NUM_LANES*32-1:0]         in_color,
    input  logic [NUM_LANES*DEPTH_BITS-1:0] in_depth,
    input  logic [NUM_LANES-1:0]            in_backface,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_LANES-1:0]            out_tmask,
    output logic [OUT_LANES*DIM_BITS-1:0]   out_pos_x,
    output logic [OUT_LANES*DIM_BITS-1:0]   out_pos_y,
    output logic [OUT_LANES*32-1:0]         out_color,
    output logic [OUT_LANES*DEPTH_BITS-1:0] out_depth,
    output logic [OUT_LANES-1:0]            out_backface,
    output logic [CHUNK_BITS-1:0]           out_chunk,
    output logic                            out_last,
    output logic [CNT_BITS-1:0]             count,
    output logic                            empty,
    output logic                            full
);

    localparam int PTR_BITS = $clog2(QUEUE_SIZE);
    localparam int OXW = OUT_LANES * DIM_BITS;
    localparam int OCW = OUT_LANES * 32;
    localparam int OZW = OUT_LANES * DEPTH_BITS;

    logic [NUM_LANES-1:0]            tmask_mem [QUEUE_SIZE];
    logic [NUM_LANES*DIM_BITS-1:0]   pos_x_mem [QUEUE_SIZE];
    logic [NUM_LANES*DIM_BITS-1:0]   pos_y_mem [QUEUE_SIZE];
    logic [NUM_LANES*32-1:0]         color_mem [QUEUE_SIZE];
    logic [NUM_LANES*DEPTH_BITS-1:0] depth_mem [QUEUE_SIZE];
    logic [NUM_LANES-1:0]            bface_mem [QUEUE_SIZE];

    logic [PTR_BITS-1:0]   rptr;
    logic [PTR_BITS-1:0]   wptr;
    logic [CHUNK_BITS-1:0] cptr;
    logic [CNT_BITS-1:0]   count_q;

    logic [NUM_LANES-1:0]  head_tmask;
    logic [CHUNK_BITS-1:0] cur;
    logic                  found;
    logic                  above;
    logic                  push_store;
    logic                  fire;
    logic                  pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_BITS'(QUEUE_SIZE));
    assign count     = count_q;
    assign in_ready  = !full;
    assign out_valid = !empty;

    // Zero-mask entries are accepted but never written.
    assign push_store = in_valid && in_ready && (|in_tmask);
    assign fire       = out_valid && out_ready;
    assign pop        = fire && out_last;

    assign head_tmask = tmask_mem[rptr];

    // First non-empty chunk at or above cptr; flag any non-empty chunk after it.
    always_comb begin
        cur   = '0;
        found = 1'b0;
        above = 1'b0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (|head_tmask[i*OUT_LANES +: OUT_LANES]) begin
                if (!found && (CHUNK_BITS'(i) >= cptr)) begin
                    found = 1'b1;
                    cur   = CHUNK_BITS'(i);
                end else if (found) begin
                    above = 1'b1;
                end
            end
        end
    end

    assign out_chunk = (NUM_CHUNKS == 1 || empty) ? '0 : cur;
    assign out_last  = !empty && ((NUM_CHUNKS == 1) || !above);

    assign out_tmask    = head_tmask[int'(cur)*OUT_LANES +: OUT_LANES];
    assign out_pos_x    = pos_x_mem[rptr][int'(cur)*OXW +: OXW];
    assign out_pos_y    = pos_y_mem[rptr][int'(cur)*OXW +: OXW];
    assign out_color    = color_mem[rptr][int'(cur)*OCW +: OCW];
    assign out_depth    = depth_mem[rptr][int'(cur)*OZW +: OZW];
    assign out_backface = bface_mem[rptr][int'(cur)*OUT_LANES +: OUT_LANES];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_store) begin
            tmask_mem[wptr] <= in_tmask;
            pos_x_mem[wptr] <= in_pos_x;
            pos_y_mem[wptr] <= in_pos_y;
            color_mem[wptr] <= in_color;
            depth_mem[wptr] <= in_depth;
            bface_mem[wptr] <= in_backface;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr    <= '0;
            wptr    <= '0;
            cptr    <= '0;
            count_q <= '0;
        end else begin
            if (push_store) begin
                wptr <= wptr + PTR_BITS'(1);
            end
            if (fire) begin
                if (out_last) begin
                    rptr <= rptr + PTR_BITS'(1);
                    cptr <= '0;
                end else begin
                    cptr <= cur + CHUNK_BITS'(1);
                end
            end
            unique case ({push_store, pop})
                2'b10:   count_q <= count_q + CNT_BITS'(1);
                2'b01:   count_q <= count_q - CNT_BITS'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rop_frag_queue.sv
// Bench for rop_frag_queue: table vectors, corner sequences and
// randomized traffic against a beat-list reference model.
module tb_rop_frag_queue;

    localparam int NL = 4;
    localparam int OL = 2;
    localparam int QS = 4;
    localparam int DW = 16;
    localparam int ZW = 24;
    localparam int CB = 1;
    localparam int CW = 3;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NL-1:0]     in_tmask;
    logic [NL*DW-1:0]  in_pos_x;
    logic [NL*DW-1:0]  in_pos_y;
    logic [NL*32-1:0]  in_color;
    logic [NL*ZW-1:0]  in_depth;
    logic [NL-1:0]     in_backface;
    logic              out_valid;
    logic              out_ready;
    logic [OL-1:0]     out_tmask;
    logic [OL*DW-1:0]  out_pos_x;
    logic [OL*DW-1:0]  out_pos_y;
    logic [OL*32-1:0]  out_color;
    logic [OL*ZW-1:0]  out_depth;
    logic [OL-1:0]     out_backface;
    logic [CB-1:0]     out_chunk;
    logic              out_last;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;

    rop_frag_queue #(
        .NUM_LANES(NL), .OUT_LANES(OL), .QUEUE_SIZE(QS),
        .DIM_BITS(DW), .DEPTH_BITS(ZW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_tmask(in_tmask),
        .in_pos_x(in_pos_x), .in_pos_y(in_pos_y), .in_color(in_color),
        .in_depth(in_depth), .in_backface(in_backface),
        .out_valid(out_valid), .out_ready(out_ready), .out_tmask(out_tmask),
        .out_pos_x(out_pos_x), .out_pos_y(out_pos_y), .out_color(out_color),
        .out_depth(out_depth), .out_backface(out_backface),
        .out_chunk(out_chunk), .out_last(out_last),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NL-1:0]    tm;
        logic [NL*DW-1:0] px;
        logic [NL*DW-1:0] py;
        logic [NL*32-1:0] col;
        logic [NL*ZW-1:0] dep;
        logic [NL-1:0]    bf;
    } ent_t;

    typedef struct {
        int chunk;
        bit last;
    } beat_t;

    typedef struct {
        logic [NL-1:0] tm;
        int            nb;
        int            c0;
        logic [OL-1:0] m0;
        int            c1;
        logic [OL-1:0] m1;
    } vec_t;

    ent_t  ents[$];
    beat_t beats[$];
    vec_t  tab[7];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each stored entry becomes a list of beats, one per non-empty chunk.
    task automatic push_model(input ent_t e);
        int last_nz;
        last_nz = -1;
        ents.push_back(e);
        for (int k = 0; k < NL / OL; k++)
            if (e.tm[k*OL +: OL] != '0) last_nz = k;
        for (int k = 0; k < NL / OL; k++)
            if (e.tm[k*OL +: OL] != '0) beats.push_back('{k, k == last_nz});
    endtask

    task automatic check_model();
        int   c;
        ent_t e;
        chk("out_valid", 128'(out_valid), 128'(beats.size() > 0));
        chk("count", 128'(count), 128'(ents.size()));
        chk("empty", 128'(empty), 128'(ents.size() == 0));
        chk("full", 128'(full), 128'(ents.size() == QS));
        chk("in_ready", 128'(in_ready), 128'(ents.size() != QS));
        if (beats.size() > 0) begin
            c = beats[0].chunk;
            e = ents[0];
            chk("out_tmask", 128'(out_tmask), 128'(e.tm[c*OL +: OL]));
            chk("out_chunk", 128'(out_chunk), 128'(c));
            chk("out_last", 128'(out_last), 128'(beats[0].last));
            chk("out_pos_x", 128'(out_pos_x), 128'(e.px[c*OL*DW +: OL*DW]));
            chk("out_pos_y", 128'(out_pos_y), 128'(e.py[c*OL*DW +: OL*DW]));
            chk("out_color", 128'(out_color), 128'(e.col[c*OL*32 +: OL*32]));
            chk("out_depth", 128'(out_depth), 128'(e.dep[c*OL*ZW +: OL*ZW]));
            chk("out_bf", 128'(out_backface), 128'(e.bf[c*OL +: OL]));
        end
    endtask

    task automatic drive(input bit v, input logic [NL-1:0] tm);
        in_valid    = v;
        in_tmask    = tm;
        in_pos_x    = {$urandom, $urandom};
        in_pos_y    = {$urandom, $urandom};
        in_color    = {$urandom, $urandom, $urandom, $urandom};
        in_depth    = {$urandom, $urandom, $urandom};
        in_backface = 4'($urandom);
    endtask

    // Advance the model for the coming edge, then step the clock.
    task automatic tick();
        bit    acc;
        beat_t b;
        ent_t  e;
        acc = in_valid && (ents.size() < QS);
        if (out_ready && beats.size() > 0) begin
            b = beats.pop_front();
            if (b.last) void'(ents.pop_front());
        end
        if (acc && in_tmask != '0) begin
            e.tm  = in_tmask;
            e.px  = in_pos_x;
            e.py  = in_pos_y;
            e.col = in_color;
            e.dep = in_depth;
            e.bf  = in_backface;
            push_model(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && beats.size() > 0; k++) begin
            check_model();
            tick();
        end
        chk(name, 128'(empty), 128'(1));
    endtask

    initial begin
        tab[0] = '{4'b1011, 2, 0, 2'b11, 1, 2'b10};
        tab[1] = '{4'b1100, 1, 1, 2'b11, 0, 2'b00};
        tab[2] = '{4'b0000, 0, 0, 2'b00, 0, 2'b00};
        tab[3] = '{4'b0001, 1, 0, 2'b01, 0, 2'b00};
        tab[4] = '{4'b0110, 2, 0, 2'b10, 1, 2'b01};
        tab[5] = '{4'b1111, 2, 0, 2'b11, 1, 2'b11};
        tab[6] = '{4'b0100, 1, 1, 2'b01, 0, 2'b00};

        reset     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'b0000);
        #2;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_empty", 128'(empty), 128'(1));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_last", 128'(out_last), 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors: one entry at a time, always-ready sink.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tab[i].tm);
            tick();
            drive(1'b0, 4'b0000);
            if (tab[i].nb == 0) begin
                chk("drop_count", 128'(count), 128'(0));
                chk("drop_valid", 128'(out_valid), 128'(0));
            end
            for (int b = 0; b < tab[i].nb; b++) begin
                chk("tab_valid", 128'(out_valid), 128'(1));
                chk("tab_chunk", 128'(out_chunk),
                    128'((b == 0) ? tab[i].c0 : tab[i].c1));
                chk("tab_tmask", 128'(out_tmask),
                    128'((b == 0) ? tab[i].m0 : tab[i].m1));
                chk("tab_last", 128'(out_last), 128'(b == tab[i].nb - 1));
                check_model();
                tick();
            end
            chk("tab_empty", 128'(empty), 128'(1));
        end

        // Fill under back-pressure; fifth push must be refused.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'($urandom_range(1, 15)));
            tick();
            check_model();
        end
        chk("full_flag", 128'(full), 128'(1));
        chk("full_count", 128'(count), 128'(4));
        chk("full_ready", 128'(in_ready), 128'(0));
        drive(1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_model();
        end
        drain("full_drain");

        // Push and final-beat pop on the same edge at count 2.
        out_ready = 1'b0;
        drive(1'b1, 4'b0001);
        tick();
        drive(1'b1, 4'b1100);
        tick();
        chk("sp_pre_count", 128'(count), 128'(2));
        out_ready = 1'b1;
        drive(1'b1, 4'b0100);
        tick();
        drive(1'b0, 4'b0000);
        out_ready = 1'b0;
        chk("sp_count", 128'(count), 128'(2));
        chk("sp_chunk", 128'(out_chunk), 128'(1));
        chk("sp_tmask", 128'(out_tmask), 128'(2'b11));
        check_model();
        drain("sp_drain");

        // Reset in the middle of a two-beat entry.
        out_ready = 1'b1;
        drive(1'b1, 4'b1111);
        tick();
        drive(1'b0, 4'b0000);
        check_model();
        tick();
        chk("mid_chunk", 128'(out_chunk), 128'(1));
        reset = 1'b0;
        #1;
        chk("mrst_valid", 128'(out_valid), 128'(0));
        chk("mrst_count", 128'(count), 128'(0));
        chk("mrst_ready", 128'(in_ready), 128'(1));
        chk("mrst_chunk", 128'(out_chunk), 128'(0));
        ents.delete();
        beats.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 4'b1010);
        tick();
        drive(1'b0, 4'b0000);
        chk("post_chunk", 128'(out_chunk), 128'(0));
        chk("post_tmask", 128'(out_tmask), 128'(2'b10));
        check_model();
        drain("post_drain");

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            check_model();
            tick();
        end
        drive(1'b0, 4'b0000);
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
